// File: rtl/single_binary_encoder.sv
// WS2812-style single-wire encoder: one 2-bit symbol per bit period becomes a width-coded high pulse on DO.
// Optional macro SBE_BIT_STROBE_EN adds a one-cycle bit_start strobe at the start of every period.
module single_binary_encoder #(
  parameter int unsigned BIT_CYCLES = 61,
  parameter int unsigned T0H_CYCLES = 20,
  parameter int unsigned T1H_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] un_encoded_data,
  output logic       DO
`ifdef SBE_BIT_STROBE_EN
  ,
  output logic       bit_start
`endif
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] PH_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HIGH0 = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] HIGH1 = CW'(T1H_CYCLES);

  if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))) begin : g_badParams
    $error("single_binary_encoder: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  logic [CW-1:0] r_ph;
  logic [1:0]    r_sym;
  logic          w_phLast;
  logic [CW-1:0] w_phNext;
  logic [1:0]    w_symNext;
  logic [CW-1:0] w_highCycles;

  // DO is computed from the next phase/symbol so it rises on the same edge the phase wraps to 0
  always_comb begin
    w_phLast     = (r_ph == PH_LAST);
    w_phNext     = w_phLast ? '0 : r_ph + CW'(1);
    w_symNext    = w_phLast ? un_encoded_data : r_sym;
    w_highCycles = '0;
    case (w_symNext)
      2'd0:    w_highCycles = HIGH0;
      2'd1:    w_highCycles = HIGH1;
      default: w_highCycles = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph  <= PH_LAST;
      r_sym <= 2'd2;
      DO    <= 1'b0;
    end else begin
      r_ph  <= w_phNext;
      r_sym <= w_symNext;
      DO    <= (w_phNext < w_highCycles);
    end
  end

`ifdef SBE_BIT_STROBE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_start <= 1'b0;
    end else begin
      bit_start <= (w_phNext == '0);
    end
  end
`endif

endmodule

// File: tb/tb_single_binary_encoder.sv
// Self-checking bench for single_binary_encoder: directed and random symbol streams against a period/offset model.
// Build with SBE_BIT_STROBE_EN defined to also check the bit_start strobe.
module tb_single_binary_encoder;

  localparam int BIT = 61;
  localparam int T0H = 20;
  localparam int T1H = 40;

  logic       clk;
  logic       reset;
  logic [1:0] unEncodedData;
  logic       dataOut;
`ifdef SBE_BIT_STROBE_EN
  logic       bitStart;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // model state: edges since reset release and the symbol owning the current period
  int         edgeIdx = 0;
  logic [1:0] modelSym = 2'd2;
  int         obsHigh = 0;
  int         lastRise = -1;
  int         cycleNum = 0;

  single_binary_encoder #(
    .BIT_CYCLES(BIT),
    .T0H_CYCLES(T0H),
    .T1H_CYCLES(T1H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .un_encoded_data(unEncodedData),
    .DO(dataOut)
`ifdef SBE_BIT_STROBE_EN
    ,
    .bit_start(bitStart)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic int widthOf(input logic [1:0] s);
    if (s == 2'd0) return T0H;
    if (s == 2'd1) return T1H;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cycleNum, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    assertCount++;
    assert (obs == exp) else begin
      failCount++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cycleNum, obs, exp);
    end
  endtask

  // one clock edge: model the edge from the inputs held across it, then sample 1 ns later
  task automatic stepCycle();
    logic expDo;
    logic expStrobe;
    int   off;
    @(posedge clk);
    if (reset) begin
      expDo     = 1'b0;
      expStrobe = 1'b0;
      edgeIdx   = 0;
    end else begin
      off = edgeIdx % BIT;
      if (off == 0) modelSym = unEncodedData;
      expDo     = (off < widthOf(modelSym));
      expStrobe = (off == 0);
      edgeIdx++;
    end
    #1;
    cycleNum++;
    checkOutput("DO", dataOut, expDo);
`ifdef SBE_BIT_STROBE_EN
    checkOutput("bit_start", bitStart, expStrobe);
`endif
    if (dataOut === 1'b1) obsHigh++;
  endtask

  task automatic applyStimulus(input logic [1:0] sym, input logic rst, input int n);
    unEncodedData = sym;
    reset         = rst;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // one aligned period; measures the high width and the spacing of rising edges
  task automatic runPeriod(input logic [1:0] sym, input int expWidth);
    int startCycle;
    obsHigh    = 0;
    startCycle = cycleNum + 1;
    unEncodedData = sym;
    reset         = 1'b0;
    stepCycle();
    if (expWidth > 0) begin
      if (lastRise >= 0) checkCount("rise spacing", startCycle - lastRise, BIT * ((startCycle - lastRise + BIT - 1) / BIT));
      lastRise = startCycle;
    end
    for (int i = 1; i < BIT; i++) stepCycle();
    checkCount("high width", obsHigh, expWidth);
  endtask

  initial begin
    logic [1:0] seqSyms [7];
    logic [1:0] rsym;
    int         k;
    seqSyms = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    reset         = 1'b1;
    unEncodedData = 2'd1;

    $display("[TB] reset held 3 cycles with symbol 1");
    applyStimulus(2'd1, 1'b1, 3);
    runPeriod(2'd1, T1H);

    $display("[TB] directed sequence 0,1,0,1,1,0,0");
    foreach (seqSyms[i]) runPeriod(seqSyms[i], widthOf(seqSyms[i]));

    $display("[TB] 50 latch periods then a zero bit");
    lastRise = -1;
    obsHigh  = 0;
    for (int i = 0; i < 50; i++) runPeriod(2'd2, 0);
    runPeriod(2'd0, T0H);
    runPeriod(2'd3, 0);

    $display("[TB] mid-period input change is ignored until the wrap");
    obsHigh = 0;
    applyStimulus(2'd0, 1'b0, 10);
    applyStimulus(2'd1, 1'b0, BIT - 10);
    checkCount("mid-change width", obsHigh, T0H);
    lastRise = -1;
    runPeriod(2'd1, T1H);

    $display("[TB] reset mid-pulse of a one bit");
    applyStimulus(2'd1, 1'b0, 30);
    applyStimulus(2'd1, 1'b1, 1);
    checkOutput("DO cut by reset", dataOut, 1'b0);
    applyStimulus(2'd1, 1'b1, 2);
    lastRise = -1;
    runPeriod(2'd1, T1H);

    $display("[TB] random symbols with random mid-period noise");
    for (int i = 0; i < 25; i++) begin
      rsym = 2'($urandom_range(0, 3));
      k    = $urandom_range(1, BIT - 1);
      obsHigh = 0;
      applyStimulus(rsym, 1'b0, k);
      applyStimulus(2'($urandom_range(0, 3)), 1'b0, BIT - k);
      checkCount("random width", obsHigh, widthOf(rsym));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
